// File: rtl/fetch_pkg.sv
// Shared types and constants for the LEGv8 instruction fetch front end.
// Entry fields are sized by the package widths; fetch_unit casts to its own ADDR_W/INSTR_W.
package fetch_pkg;

  localparam int unsigned ENTRY_ADDR_W  = 32;
  localparam int unsigned ENTRY_INSTR_W = 32;
  localparam int unsigned PC_STEP       = 4;

  typedef enum logic [0:0] {
    FETCH,
    DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [ENTRY_ADDR_W-1:0]  pc;
    logic [ENTRY_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Fetch unit handshake bundle: instruction-memory request/response, redirect, decode output.
// The master modport is the fetch unit; the slave modport is memory/execute/decode.
interface fetch_if #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned INSTR_W = 32
);

  logic               imem_req_valid;
  logic [ADDR_W-1:0]  imem_req_addr;
  logic               imem_req_ready;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_instr;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               out_valid;
  logic [ADDR_W-1:0]  out_pc;
  logic [INSTR_W-1:0] out_instr;
  logic               out_ready;

  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_instr, redirect_valid, redirect_pc,
    input  out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_instr, redirect_valid, redirect_pc,
    output out_ready
  );

endinterface

// File: rtl/fetch_queue.sv
// Circular prefetch FIFO of fetch_entry_t with count, push/pop/flush and full/empty flags.
// Flush wins over push; push on full and pop on empty are ignored.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  fetch_entry_t       push_entry,
  input  logic               pop,
  input  logic               flush,
  output fetch_entry_t       head_entry,
  output logic               full,
  output logic               empty,
  output logic [CNT_W-1:0]   count
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) tail_q <= tail_q + PTR_W'(1);
      if (do_pop)  head_q <= head_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[tail_q] <= push_entry;
  end

  assign head_entry = mem_q[head_q];
  assign count      = count_q;

endmodule

// File: rtl/fetch_unit.sv
// LEGv8 fetch front end: credit-limited PC generation, in-order prefetch queue, redirect flush.
// Define FETCH_BYPASS_EN to forward a kept response straight to decode when the queue is empty.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned      DEPTH    = 4,
  parameter int unsigned      ADDR_W   = 32,
  parameter int unsigned      INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic      clk,
  input  logic      reset,
  fetch_if.master   bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fetch_state_t      state_q, state_d;
  logic              running_q;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [CNT_W-1:0]  drop_q, drop_d;

  logic [CNT_W-1:0]  q_count;
  logic              q_full, q_empty, q_push, q_pop;
  fetch_entry_t      push_entry, head_entry, out_entry;
  logic              credit_ok, req_fire, rsp_kept;

  // Queued plus in-flight may never exceed DEPTH, so a response always finds a free slot.
  assign credit_ok = !q_full &&
                     (({1'b0, q_count} + {1'b0, outstanding_q}) < (CNT_W + 1)'(DEPTH));

  assign bus.imem_req_valid = running_q && (state_q == FETCH) && credit_ok &&
                              !bus.redirect_valid;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  assign rsp_kept         = bus.imem_rsp_valid && (drop_q == '0) && !bus.redirect_valid;
  assign push_entry.pc    = ENTRY_ADDR_W'(rsp_pc_q);
  assign push_entry.instr = ENTRY_INSTR_W'(bus.imem_rsp_instr);

`ifdef FETCH_BYPASS_EN
  logic bypass;
  assign bypass        = rsp_kept && q_empty;
  assign bus.out_valid = !q_empty || bypass;
  assign out_entry     = q_empty ? push_entry : head_entry;
  assign q_push        = rsp_kept && !(bypass && bus.out_ready);
`else
  assign bus.out_valid = !q_empty;
  assign out_entry     = head_entry;
  assign q_push        = rsp_kept;
`endif

  assign q_pop         = !q_empty && bus.out_ready;
  assign bus.out_pc    = bus.out_valid ? ADDR_W'(out_entry.pc) : '0;
  assign bus.out_instr = bus.out_valid ? INSTR_W'(out_entry.instr) : '0;

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .push       (q_push),
    .push_entry (push_entry),
    .pop        (q_pop),
    .flush      (bus.redirect_valid),
    .head_entry (head_entry),
    .full       (q_full),
    .empty      (q_empty),
    .count      (q_count)
  );

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    drop_d        = drop_q;
    outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(bus.imem_rsp_valid);

    if (req_fire) fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
    if (rsp_kept) rsp_pc_d = rsp_pc_q + ADDR_W'(PC_STEP);

    if (bus.redirect_valid) begin
      // Everything still in flight after this cycle's response belongs to the old stream.
      fetch_pc_d = bus.redirect_pc;
      rsp_pc_d   = bus.redirect_pc;
      drop_d     = outstanding_d;
      state_d    = (outstanding_d != '0) ? DRAIN : FETCH;
    end else begin
      if (bus.imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - CNT_W'(1);
      case (state_q)
        FETCH:   state_d = FETCH;
        DRAIN:   if (drop_d == '0) state_d = FETCH;
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= FETCH;
      running_q     <= 1'b0;
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      state_q       <= state_d;
      running_q     <= 1'b1;
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit (default build): vector table plus corner-case sequences.
// Memory model answers in order with a per-request latency; instruction = ~address.
module tb_fetch_unit;

  logic clk;
  logic reset;

  fetch_if #(.ADDR_W(32), .INSTR_W(32)) bus ();

  fetch_unit #(
    .DEPTH    (4),
    .ADDR_W   (32),
    .INSTR_W  (32),
    .RESET_PC (32'h0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    logic        rst;
    int          lat;
    logic        mr;
    logic        ordy;
    logic        rd;
    logic [31:0] rpc;
    logic        erv;
    logic [31:0] eaddr;
    logic        eov;
    logic [31:0] epc;
  } vec_t;

  pend_t pend[$];
  vec_t  tbl[$];
  int    cyc;
  int    cur_lat;
  int    nerr;
  int    nchk;

  logic        s_rv, s_ov;
  logic [31:0] s_addr, s_pc, s_instr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, sample 1ns later, log accepted requests.
  task automatic tick(input logic rst, input logic mr, input logic ordy, input logic rd,
                      input logic [31:0] rpc);
    pend_t p;
    reset              = !rst;
    bus.imem_req_ready = mr;
    bus.out_ready      = ordy;
    bus.redirect_valid = rd;
    bus.redirect_pc    = rpc;
    if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_instr = ~pend[0].addr;
      void'(pend.pop_front());
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_instr = '0;
    end
    #1;
    s_rv    = bus.imem_req_valid;
    s_addr  = bus.imem_req_addr;
    s_ov    = bus.out_valid;
    s_pc    = bus.out_pc;
    s_instr = bus.out_instr;
    if (rst) begin
      pend.delete();
    end else if (s_rv && mr) begin
      p.addr = s_addr;
      p.due  = cyc + cur_lat;
      pend.push_back(p);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    tick(1'b1, 1'b1, 1'b1, 1'b0, '0);
    tick(1'b1, 1'b1, 1'b1, 1'b0, '0);
  endtask

  task automatic add(input logic rst, input int lat, input logic mr, input logic ordy,
                     input logic rd, input logic [31:0] rpc, input logic erv,
                     input logic [31:0] eaddr, input logic eov, input logic [31:0] epc);
    vec_t v;
    v.rst = rst;  v.lat = lat;  v.mr = mr;  v.ordy = ordy;  v.rd = rd;  v.rpc = rpc;
    v.erv = erv;  v.eaddr = eaddr;  v.eov = eov;  v.epc = epc;
    tbl.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          nreq;
    int          nx;
    logic [31:0] exp_pc;

    nerr = 0;
    nchk = 0;
    cyc  = 0;
    cur_lat = 1;
    reset = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_instr = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b0;
    @(negedge clk);

    // Sequential fetch, L=1: requests 0,4,8..., outputs start two cycles after the first request.
    add(1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 1, 0, 0, 0, 0,            0, 0);
    add(0, 1, 1, 1, 0, 0, 1, 32'h0,        0, 0);
    add(0, 1, 1, 1, 0, 0, 1, 32'h4,        0, 0);
    add(0, 1, 1, 1, 0, 0, 1, 32'h8,        1, 32'h0);
    add(0, 1, 1, 1, 0, 0, 1, 32'hC,        1, 32'h4);
    add(0, 1, 1, 1, 0, 0, 1, 32'h10,       1, 32'h8);
    add(0, 1, 1, 1, 0, 0, 1, 32'h14,       1, 32'hC);
    // L=3, redirect to 0x100 with three in flight (first one returns in the redirect cycle).
    add(1, 3, 1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 3, 1, 1, 0, 0, 0, 0, 0, 0);
    add(0, 3, 1, 1, 0, 0,            0, 0,        0, 0);
    add(0, 3, 1, 1, 0, 0,            1, 32'h0,    0, 0);
    add(0, 3, 1, 1, 0, 0,            1, 32'h4,    0, 0);
    add(0, 3, 1, 1, 0, 0,            1, 32'h8,    0, 0);
    add(0, 3, 1, 1, 1, 32'h100,      0, 0,        0, 0);
    add(0, 3, 1, 1, 0, 0,            0, 0,        0, 0);
    add(0, 3, 1, 1, 0, 0,            0, 0,        0, 0);
    add(0, 3, 1, 1, 0, 0,            1, 32'h100,  0, 0);
    add(0, 3, 1, 1, 0, 0,            1, 32'h104,  0, 0);
    add(0, 3, 1, 1, 0, 0,            1, 32'h108,  0, 0);
    add(0, 3, 1, 1, 0, 0,            1, 32'h10C,  0, 0);
    add(0, 3, 1, 1, 0, 0,            0, 0,        1, 32'h100);
    add(0, 3, 1, 1, 0, 0,            1, 32'h110,  1, 32'h104);
    // Redirect with nothing in flight to the top of the address space, then wrap.
    add(1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 1, 0, 0,            0, 0,            0, 0);
    add(0, 1, 1, 1, 1, 32'hFFFFFFFC, 0, 0,            0, 0);
    add(0, 1, 1, 1, 0, 0,            1, 32'hFFFFFFFC, 0, 0);
    add(0, 1, 1, 1, 0, 0,            1, 32'h0,        0, 0);
    add(0, 1, 1, 1, 0, 0,            1, 32'h4,        1, 32'hFFFFFFFC);
    add(0, 1, 1, 1, 0, 0,            1, 32'h8,        1, 32'h0);
    add(0, 1, 1, 1, 0, 0,            1, 32'hC,        1, 32'h4);

    for (int i = 0; i < tbl.size(); i++) begin
      cur_lat = tbl[i].lat;
      tick(tbl[i].rst, tbl[i].mr, tbl[i].ordy, tbl[i].rd, tbl[i].rpc);
      if (!tbl[i].rst) begin
        check($sformatf("row%0d req_valid", i), 32'(s_rv), 32'(tbl[i].erv));
        if (tbl[i].erv) check($sformatf("row%0d req_addr", i), s_addr, tbl[i].eaddr);
        check($sformatf("row%0d out_valid", i), 32'(s_ov), 32'(tbl[i].eov));
        if (tbl[i].eov) begin
          check($sformatf("row%0d out_pc", i), s_pc, tbl[i].epc);
          check($sformatf("row%0d out_instr", i), s_instr, ~tbl[i].epc);
        end
      end
    end

    // Decode stalled 12 cycles: credits cap requests at 4, head held at 0x0, then no loss.
    cur_lat = 1;
    do_reset();
    nreq = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, 1'b1, 1'b0, 1'b0, '0);
      if (s_rv) nreq++;
      if (s_ov) check("stall out_pc", s_pc, 32'h0);
    end
    check("stall request count", 32'(nreq), 32'd4);
    check("stall req_valid", 32'(s_rv), 32'd0);
    check("stall out_valid", 32'(s_ov), 32'd1);
    exp_pc = 32'h0;
    nx = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b1, 1'b1, 1'b0, '0);
      if (s_ov) begin
        check("drain out_pc", s_pc, exp_pc);
        check("drain out_instr", s_instr, ~exp_pc);
        exp_pc += 32'd4;
        nx++;
      end
    end
    check("drain transfers >= 12", 32'(nx >= 12), 32'd1);

    // Redirect coinciding with a response and an output transfer.
    do_reset();
    tick(1'b0, 1'b1, 1'b1, 1'b0, '0);
    tick(1'b0, 1'b1, 1'b1, 1'b0, '0);
    tick(1'b0, 1'b1, 1'b1, 1'b0, '0);
    tick(1'b0, 1'b1, 1'b1, 1'b1, 32'h200);
    check("coincide transfer valid", 32'(s_ov), 32'd1);
    check("coincide transfer pc", s_pc, 32'h0);
    tick(1'b0, 1'b1, 1'b1, 1'b0, '0);
    check("coincide out_valid next", 32'(s_ov), 32'd0);
    check("coincide req_valid next", 32'(s_rv), 32'd1);
    check("coincide req_addr next", s_addr, 32'h200);
    tick(1'b0, 1'b1, 1'b1, 1'b0, '0);
    check("coincide no stale entry", 32'(s_ov), 32'd0);
    tick(1'b0, 1'b1, 1'b1, 1'b0, '0);
    check("coincide new out_valid", 32'(s_ov), 32'd1);
    check("coincide new out_pc", s_pc, 32'h200);

    // Reset while draining: drop count and state clear, fetch restarts at the reset PC.
    cur_lat = 4;
    do_reset();
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b1, 1'b0, '0);
    tick(1'b0, 1'b1, 1'b1, 1'b1, 32'h300);
    tick(1'b0, 1'b1, 1'b1, 1'b0, '0);
    check("drain req_valid", 32'(s_rv), 32'd0);
    cur_lat = 1;
    do_reset();
    tick(1'b0, 1'b1, 1'b1, 1'b0, '0);
    check("reset req_valid", 32'(s_rv), 32'd0);
    check("reset out_valid", 32'(s_ov), 32'd0);
    check("reset out_pc", s_pc, 32'h0);
    check("reset out_instr", s_instr, 32'h0);
    tick(1'b0, 1'b1, 1'b1, 1'b0, '0);
    check("post-reset req_valid", 32'(s_rv), 32'd1);
    check("post-reset req_addr", s_addr, 32'h0);
    tick(1'b0, 1'b1, 1'b1, 1'b0, '0);
    tick(1'b0, 1'b1, 1'b1, 1'b0, '0);
    check("post-reset out_valid", 32'(s_ov), 32'd1);
    check("post-reset out_pc", s_pc, 32'h0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end for the LEGv8 core. It generates sequential PCs, issues requests to instruction memory over a valid/ready handshake, and absorbs variable memory latency in a small in-order prefetch queue. It presents {pc, instruction} pairs to decode over a valid/ready handshake. A branch/redirect from execute flushes all queued and in-flight fetches and restarts fetch at the new PC.

## Interface
- DEPTH, 4: prefetch queue entries, a power of 2 and at least 2; also the credit limit on outstanding requests.
- ADDR_W, 32: PC/address width.
- INSTR_W, 32: instruction width.
- RESET_PC, 0: first fetch address after reset.

- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low; 0 = reset.
- imem_req_valid  out  1  request to instruction memory.
- imem_req_addr  out  ADDR_W  request address; the current fetch PC.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_rsp_valid  in  1  response returned; in order, at least 1 cycle after acceptance.
- imem_rsp_instr  in  INSTR_W  response data.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  ADDR_W  new fetch PC.
- out_valid  out  1  decode-side entry valid.
- out_pc  out  ADDR_W  PC of the presented instruction.
- out_instr  out  INSTR_W  presented instruction.
- out_ready  in  1  decode consumes the entry.

## Operation
- Reset (reset=0 at an edge) sets:
  - fetch_pc=RESET_PC, queue empty, outstanding=0, drop=0, state=FETCH.
  - Outputs: imem_req_valid=0, out_valid=0, out_pc=0, out_instr=0.
- Credit rule: imem_req_valid=1 only when state=FETCH, queue count + outstanding < DEPTH, and redirect_valid=0.
- Request handshake: a request is accepted when imem_req_valid && imem_req_ready.
  - On acceptance: fetch_pc += 4, modulo 2^ADDR_W, wrapping silently; outstanding += 1.
  - imem_req_addr stays stable while imem_req_valid && !imem_req_ready.
- Response handling: each response decrements outstanding.
  - If drop>0, the response is discarded and drop decrements.
  - Otherwise {pc, instr} is pushed, with pc taken from a response-PC counter that advances by 4 per kept response.
- Output handshake: an entry transfers on out_valid && out_ready; the queue pops.
  - out_pc and out_instr hold stable while out_valid && !out_ready.
- Redirect (redirect_valid=1): the queue is flushed; fetch_pc and the response-PC counter are set to redirect_pc.
  - drop = outstanding after this cycle's response is accounted for. A response arriving in the redirect cycle is always discarded.
  - A transfer in the same cycle completes. out_valid=0 in the next cycle.
- FSM:
  - FETCH → DRAIN on redirect with nonzero remaining in-flight requests.
  - DRAIN issues no requests and goes → FETCH on the cycle the last dropped response arrives.
  - A redirect in DRAIN reloads the PC and keeps DRAIN; drop is recomputed.
  - A redirect with nothing in flight stays in FETCH, and requesting resumes next cycle.
- Full queue: the credit rule guarantees no push to a full queue; a response into a full queue cannot occur.
- Empty queue with out_ready=1: out_valid=0 and no pop.

## Timing
- First request: the cycle after reset returns to 1, with imem_req_addr=RESET_PC.
- Fetch-to-decode latency:
  - Request accepted at cycle N, response at N+L.
  - out_valid asserts at N+L+1, or at N+L with bypass (see Configuration).
- Throughput: 1 instruction/cycle sustained when L ≤ DEPTH−1 and decode is always ready.
- Redirect at cycle R with k requests in flight: the first new request issues the cycle after the k-th drop, or at R+1 if k=0.

## Configuration
- FETCH_BYPASS_EN defined:
  - A kept response arriving while the queue is empty drives out_valid/out_pc/out_instr combinationally in the same cycle.
  - If out_ready=1, it is consumed without being written to the queue; otherwise it is pushed.
- Undefined: outputs come only from registered queue state, so every instruction spends at least one cycle in the queue.

## Structure
- Package fetch_pkg:
  - fetch_state_t enum {FETCH, DRAIN};
  - fetch_entry_t struct {pc, instr};
  - PC_STEP=4.
- Sub-module fetch_queue: circular FIFO of fetch_entry_t with head/tail pointers wrapping at DEPTH, a count register, push/pop/flush, and full/empty outputs.
  - Push and pop in the same cycle leave count unchanged.
  - Flush has priority over push.

## Test plan
- Reset, memory with L=1, always ready, decode always ready → requests at 0x0, 0x4, 0x8…; out_pc sequence 0x0, 0x4, 0x8 with one output per cycle after fill.
- out_ready=0 for 10 cycles, L=1, DEPTH=4 → at most 4 requests outstanding plus queued; imem_req_valid=0 afterwards; out_pc holds 0x0 stable; no entry lost once ready returns.
- Redirect to 0x100 with 3 requests in flight (L=3) → 3 responses dropped; no request until the third drop; then request 0x100; next out_pc=0x100.
- Redirect in the same cycle as a response and an output transfer → transferred entry counted once, response discarded, out_valid=0 next cycle.
- reset=0 asserted mid-DRAIN → state FETCH, queue empty, next request at RESET_PC.
- Redirect to 0xFFFFFFFC → requests 0xFFFFFFFC then 0x00000000 (wrap).
